// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and encodings for the data-memory arbiter, MEM stage and data memory
package dmem_arb_pkg;
    typedef enum logic [1:0] {OWN_NONE, OWN_P0, OWN_P1} owner_e;
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam int STARVE_LIMIT_DEF = 4;
endpackage

// File: rtl/arb_starve_cnt.sv
// arb_starve_cnt: saturating port-1 wait counter, cleared whenever port 1 is not waiting
module arb_starve_cnt #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic wait_i,
    output logic limit_hit_o
);
    localparam logic [3:0] LIM = 4'(LIMIT);
    logic [3:0] cnt_q, cnt_d;
    always_comb cnt_d = !wait_i ? 4'd0 : (cnt_q == LIM) ? cnt_q : cnt_q + 4'd1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
    assign limit_hit_o = cnt_q == LIM;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: fixed-priority data-memory port share between MEM stage (port 0) and a secondary master (port 1)
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req_i,
    input  logic              p0_we_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [DATA_W-1:0] p0_wdata_i,
    input  logic [2:0]        p0_ctrl_i,
    output logic              p0_gnt_o,
    output logic              p0_rvalid_o,
    output logic [DATA_W-1:0] p0_rdata_o,
    input  logic              p1_req_i,
    input  logic              p1_we_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_wdata_i,
    input  logic [2:0]        p1_ctrl_i,
    output logic              p1_gnt_o,
    output logic              p1_rvalid_o,
    output logic [DATA_W-1:0] p1_rdata_o,
    output logic              stall_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [2:0]        mem_ctrl_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);
    owner_e owner_q, owner_d;
    logic   limit_hit;

    arb_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk        (clk),
        .rst        (rst),
        .wait_i     (p1_req_i & ~p1_gnt_o),
        .limit_hit_o(limit_hit)
    );

    // port 1 takes the slot when port 0 is idle or port 1 has waited long enough
    assign p1_gnt_o = p1_req_i & (~p0_req_i | limit_hit);
    assign p0_gnt_o = p0_req_i & ~p1_gnt_o;
    assign stall_o  = p0_req_i & ~p0_gnt_o;

    always_comb begin
        mem_read_o  = (p0_gnt_o & ~p0_we_i) | (p1_gnt_o & ~p1_we_i);
        mem_write_o = (p0_gnt_o & p0_we_i) | (p1_gnt_o & p1_we_i);
        mem_addr_o  = p1_gnt_o ? p1_addr_i  : p0_gnt_o ? p0_addr_i  : '0;
        mem_wdata_o = p1_gnt_o ? p1_wdata_i : p0_gnt_o ? p0_wdata_i : '0;
        mem_ctrl_o  = p1_gnt_o ? p1_ctrl_i  : p0_gnt_o ? p0_ctrl_i  : '0;
        owner_d     = (p1_gnt_o & ~p1_we_i) ? OWN_P1 : (p0_gnt_o & ~p0_we_i) ? OWN_P0 : OWN_NONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) owner_q <= OWN_NONE;
        else     owner_q <= owner_d;
    end

    assign p0_rvalid_o = owner_q == OWN_P0;
    assign p1_rvalid_o = owner_q == OWN_P1;
    assign p0_rdata_o  = p0_rvalid_o ? mem_rdata_i : '0;
    assign p1_rdata_o  = p1_rvalid_o ? mem_rdata_i : '0;

    // a waiting requester may withdraw, but must not alter its payload
    a_p0_stable: assert property (@(posedge clk) disable iff (rst)
        p0_req_i && !p0_gnt_o |=> !p0_req_i || $stable({p0_we_i, p0_addr_i, p0_wdata_i, p0_ctrl_i}));
    a_p1_stable: assert property (@(posedge clk) disable iff (rst)
        p1_req_i && !p1_gnt_o |=> !p1_req_i || $stable({p1_we_i, p1_addr_i, p1_wdata_i, p1_ctrl_i}));
endmodule
